// File: rtl/ssd_pkg.sv
// rtl/ssd_pkg.sv - shared seven-segment types, hex pattern table and decode helper
package ssd_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b0000000;

    // Patterns are {g,f,e,d,c,b,a}, active-high, indexed by nibble value
    localparam seg_t SEG_HEX [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    typedef enum logic [1:0] {
        SETTLE,
        TRACK,
        HELD
    } cap_state_t;

    function automatic logic [4:0] seg2hex(input seg_t p);
        logic [4:0] r;
        r = 5'b0;
        for (int i = 0; i < 16; i++) begin
            if (p == SEG_HEX[i]) begin
                r = {1'b1, 4'(i)};
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ssd_in_sync.sv
// rtl/ssd_in_sync.sv - two-flop input synchroniser, flops reset to 0
module ssd_in_sync #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ssd_capture_decoder.sv
// rtl/ssd_capture_decoder.sv - decodes multiplexed SSD lines back to per-digit nibbles; SSD_CAP_SYNC_EN adds input synchroniser
module ssd_capture_decoder
    import ssd_pkg::*;
#(
    parameter int SETTLE_CYC = 16,
    parameter int STABLE_CYC = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       chip_sel,
    input  logic [6:0] seg,
    output logic [3:0] digit0,
    output logic [3:0] digit1,
    output logic [1:0] dig_valid,
    output logic       upd,
    output logic       upd_sel,
    output logic       err
);

    localparam int CNT_MAX = (SETTLE_CYC > STABLE_CYC) ? SETTLE_CYC : STABLE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] STABLE_END = CNT_W'(STABLE_CYC - 1);

    logic s_sel;
    seg_t s_seg;

`ifdef SSD_CAP_SYNC_EN
    logic [7:0] sync_q;

    ssd_in_sync #(.W(8)) u_in_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({chip_sel, seg}),
        .q     (sync_q)
    );

    assign s_sel = sync_q[7];
    assign s_seg = sync_q[6:0];
`else
    assign s_sel = chip_sel;
    assign s_seg = seg;
`endif

    logic             prev_sel;
    seg_t             prev_seg;
    cap_state_t       state;
    logic [CNT_W-1:0] cnt;

    logic             sel_chg;
    logic             seg_chg;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       dec;
    logic             hit;
    logic [3:0]       nib;
    logic             is_blank;
    logic [3:0]       cur_dig;
    logic             cur_val;
    logic             commit_chg;

    assign sel_chg  = (s_sel != prev_sel);
    assign seg_chg  = (s_seg != prev_seg);
    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 1'b1;
    assign dec      = seg2hex(s_seg);
    assign hit      = dec[4];
    assign nib      = dec[3:0];
    assign is_blank = (s_seg == SEG_BLANK);

    // upd only fires when the commit would actually alter what the digit reports
    always_comb begin
        cur_dig    = s_sel ? digit1 : digit0;
        cur_val    = dig_valid[s_sel];
        commit_chg = 1'b0;
        if (hit) begin
            commit_chg = !cur_val || (cur_dig != nib);
        end else if (is_blank) begin
            commit_chg = cur_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_sel  <= 1'b0;
            prev_seg  <= SEG_BLANK;
            state     <= SETTLE;
            cnt       <= '0;
            digit0    <= 4'h0;
            digit1    <= 4'h0;
            dig_valid <= 2'b00;
            upd       <= 1'b0;
            upd_sel   <= 1'b0;
            err       <= 1'b0;
        end else begin
            prev_sel <= s_sel;
            prev_seg <= s_seg;
            upd      <= 1'b0;
            err      <= 1'b0;
            case (state)
                SETTLE: begin
                    if (sel_chg) begin
                        cnt <= '0;
                    end else if (cnt == SETTLE_END) begin
                        state <= TRACK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                TRACK: begin
                    if (sel_chg) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (seg_chg) begin
                        cnt <= '0;
                    end else if (cnt == STABLE_END) begin
                        state <= HELD;
                        cnt   <= '0;
                        if (hit) begin
                            if (s_sel) begin
                                digit1 <= nib;
                            end else begin
                                digit0 <= nib;
                            end
                            dig_valid[s_sel] <= 1'b1;
                        end else if (is_blank) begin
                            dig_valid[s_sel] <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        upd <= commit_chg;
                        if (commit_chg) begin
                            upd_sel <= s_sel;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                HELD: begin
                    if (sel_chg) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end else if (seg_chg) begin
                        state <= TRACK;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= SETTLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
